// File: rtl/transducer_fire_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : transducer_fire_sequencer
// Purpose  : Per-channel fire table plus arm/fire/re-arm shot-train controller
//            with watchdog, warning aggregation and a latched fault.
// Revision : 1.0 - initial release
// ============================================================================
module transducer_fire_sequencer #(
    parameter int N_CH      = 8,
    parameter int PD_W      = 16,
    parameter int CT_W      = 9,
    parameter int TIMEOUT_W = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfgWe,
    input  logic [$clog2(N_CH)-1:0]   cfgAddr,
    input  logic [PD_W-1:0]           cfgPhaseDelay,
    input  logic [CT_W-1:0]           cfgChargeTime,
    input  logic                      cfgMask,
    input  logic                      trigger,
    input  logic                      abort,
    input  logic                      faultClear,
    input  logic [15:0]               numFires,
    input  logic [15:0]               interFireGap,
    output logic [N_CH*PD_W-1:0]      chPhaseDelay,
    output logic [N_CH*CT_W-1:0]      chChargeTime,
    output logic [N_CH-1:0]           chMask,
    output logic                      onYourMark,
    output logic                      GOGOGO_EXCLAMATION,
    output logic                      chRst,
    input  logic [N_CH-1:0]           chFireComplete,
    input  logic [N_CH-1:0]           chWarning,
    output logic                      busy,
    output logic                      done,
    output logic                      fault,
    output logic [N_CH-1:0]           faultChannels,
    output logic [15:0]               fireCount
);

    localparam int c_addrW = $clog2(N_CH);
    localparam logic [c_addrW:0] c_nCh = (c_addrW + 1)'(N_CH);
    // Last watchdog value still inside the window: 2^W-1 FIRE cycles in total.
    localparam logic [TIMEOUT_W-1:0] c_wdLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    localparam logic [2:0] c_stIdle    = 3'd0;
    localparam logic [2:0] c_stArm     = 3'd1;
    localparam logic [2:0] c_stFire    = 3'd2;
    localparam logic [2:0] c_stRelease = 3'd3;
    localparam logic [2:0] c_stGap     = 3'd4;
    localparam logic [2:0] c_stFault   = 3'd5;
    localparam logic [2:0] c_stClear   = 3'd6;

    logic [PD_W-1:0]      r_phaseDelay [N_CH];
    logic [CT_W-1:0]      r_chargeTime [N_CH];
    logic [N_CH-1:0]      r_mask;

    logic [2:0]           r_state;
    logic [2:0]           w_nextState;
    logic [15:0]          r_numFires;
    logic [15:0]          r_gap;
    logic [15:0]          r_fireCount;
    logic [15:0]          r_gapCnt;
    logic [TIMEOUT_W-1:0] r_wd;
    logic                 r_armCnt;
    logic                 r_aborted;
    logic                 r_done;
    logic [N_CH-1:0]      r_faultChannels;

    logic                 w_cfgWrite;
    logic                 w_warn;
    logic                 w_allComplete;
    logic                 w_activeState;
    logic                 w_takeAbort;
    logic                 w_shotDone;
    logic                 w_trainDone;
    logic [N_CH-1:0]      w_faultSnap;

    assign w_cfgWrite    = cfgWe && (r_state == c_stIdle) && ({1'b0, cfgAddr} < c_nCh);
    assign w_warn        = |chWarning;
    assign w_allComplete = &chFireComplete;
    assign w_activeState = (r_state == c_stArm) || (r_state == c_stFire) ||
                           (r_state == c_stRelease) || (r_state == c_stGap);

    // ------------------------------------------------------------------
    // Configuration table
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_phaseDelay[i] <= '0;
                r_chargeTime[i] <= '0;
            end
            r_mask <= '0;
        end else if (w_cfgWrite) begin
            r_phaseDelay[cfgAddr] <= cfgPhaseDelay;
            r_chargeTime[cfgAddr] <= cfgChargeTime;
            r_mask[cfgAddr]       <= cfgMask;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_tableOut
            assign chPhaseDelay[gi*PD_W +: PD_W] = r_phaseDelay[gi];
            assign chChargeTime[gi*CT_W +: CT_W] = r_chargeTime[gi];
        end
    endgenerate
    assign chMask = r_mask;

    // ------------------------------------------------------------------
    // Shot-train state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_stIdle;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState        = r_state;
        w_takeAbort        = 1'b0;
        w_shotDone         = 1'b0;
        w_trainDone        = 1'b0;
        w_faultSnap        = '0;
        onYourMark         = 1'b0;
        GOGOGO_EXCLAMATION = 1'b0;
        chRst              = rst;
        busy               = 1'b0;
        fault              = 1'b0;

        case (r_state)
            c_stIdle: begin
                if (trigger && (numFires != 16'd0)) begin
                    w_nextState = c_stArm;
                end
            end
            c_stArm: begin
                if (abort) begin
                    w_nextState = c_stRelease;
                    w_takeAbort = 1'b1;
                end else if (r_armCnt) begin
                    w_nextState = c_stFire;
                end
            end
            c_stFire: begin
                // Abort beats completion, completion beats the watchdog.
                if (abort) begin
                    w_nextState = c_stRelease;
                    w_takeAbort = 1'b1;
                end else if (w_allComplete) begin
                    w_nextState = c_stRelease;
                end else if (r_wd == c_wdLast) begin
                    w_nextState = c_stFault;
                end
            end
            c_stRelease: begin
                if (r_aborted) begin
                    w_nextState = c_stIdle;
                end else begin
                    w_shotDone = 1'b1;
                    if (r_fireCount + 16'd1 == r_numFires) begin
                        w_nextState = c_stIdle;
                        w_trainDone = 1'b1;
                    end else if (r_gap != 16'd0) begin
                        w_nextState = c_stGap;
                    end else begin
                        w_nextState = c_stArm;
                    end
                end
            end
            c_stGap: begin
                if (abort) begin
                    w_nextState = c_stRelease;
                    w_takeAbort = 1'b1;
                end else if (r_gapCnt == r_gap - 16'd1) begin
                    w_nextState = c_stArm;
                end
            end
            c_stFault: begin
                if (faultClear) begin
                    w_nextState = c_stClear;
                end
            end
            c_stClear: begin
                w_nextState = c_stIdle;
            end
            default: begin
                w_nextState = c_stIdle;
            end
        endcase

        if (w_activeState && w_warn) begin
            w_nextState = c_stFault;
            w_faultSnap = chWarning;
            w_takeAbort = 1'b0;
            w_shotDone  = 1'b0;
            w_trainDone = 1'b0;
        end

        if (!rst) begin
            onYourMark         = (r_state == c_stArm) || (r_state == c_stFire);
            GOGOGO_EXCLAMATION = (r_state == c_stFire);
            chRst              = (r_state == c_stRelease) || (r_state == c_stClear);
            busy               = (r_state != c_stIdle);
            fault              = (r_state == c_stFault);
        end
    end

    // ------------------------------------------------------------------
    // Train bookkeeping, phase counters and fault capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_numFires      <= '0;
            r_gap           <= '0;
            r_fireCount     <= '0;
            r_gapCnt        <= '0;
            r_wd            <= '0;
            r_armCnt        <= 1'b0;
            r_aborted       <= 1'b0;
            r_done          <= 1'b0;
            r_faultChannels <= '0;
        end else begin
            // Phase counters restart on every state change.
            if (w_nextState != r_state) begin
                r_armCnt <= 1'b0;
                r_wd     <= '0;
                r_gapCnt <= '0;
            end else begin
                if (r_state == c_stArm)  r_armCnt <= 1'b1;
                if (r_state == c_stFire) r_wd     <= r_wd + TIMEOUT_W'(1);
                if (r_state == c_stGap)  r_gapCnt <= r_gapCnt + 16'd1;
            end

            if ((r_state == c_stIdle) && (w_nextState == c_stArm)) begin
                r_numFires  <= numFires;
                r_gap       <= interFireGap;
                r_fireCount <= '0;
            end else if (w_shotDone) begin
                r_fireCount <= r_fireCount + 16'd1;
            end

            if (w_takeAbort) begin
                r_aborted <= 1'b1;
            end else if (r_state == c_stRelease) begin
                r_aborted <= 1'b0;
            end

            r_done <= w_trainDone;

            if ((w_nextState == c_stFault) && (r_state != c_stFault)) begin
                r_faultChannels <= w_faultSnap;
            end else if (w_nextState == c_stClear) begin
                r_faultChannels <= '0;
            end
        end
    end

    assign done          = r_done;
    assign fireCount     = r_fireCount;
    assign faultChannels = r_faultChannels;

endmodule
`default_nettype wire

// File: tb/tb_transducer_fire_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_transducer_fire_sequencer
// Purpose  : Directed and random shot trains against a phase-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transducer_fire_sequencer;

    localparam int N_CH       = 8;
    localparam int PD_W       = 16;
    localparam int CT_W       = 9;
    localparam int TIMEOUT_W  = 4;
    localparam int FIRE_LIMIT = (1 << TIMEOUT_W) - 1;

    localparam int P_IDLE = 0, P_ARM = 1, P_FIRE = 2, P_REL = 3, P_GAP = 4, P_FAULT = 5, P_CLR = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfgWe;
    logic [2:0]           cfgAddr;
    logic [PD_W-1:0]      cfgPhaseDelay;
    logic [CT_W-1:0]      cfgChargeTime;
    logic                 cfgMask;
    logic                 trigger;
    logic                 abort;
    logic                 faultClear;
    logic [15:0]          numFires;
    logic [15:0]          interFireGap;
    logic [N_CH*PD_W-1:0] chPhaseDelay;
    logic [N_CH*CT_W-1:0] chChargeTime;
    logic [N_CH-1:0]      chMask;
    logic                 onYourMark;
    logic                 GOGOGO_EXCLAMATION;
    logic                 chRst;
    logic [N_CH-1:0]      chFireComplete;
    logic [N_CH-1:0]      chWarning;
    logic                 busy;
    logic                 done;
    logic                 fault;
    logic [N_CH-1:0]      faultChannels;
    logic [15:0]          fireCount;

    always #5 clk = ~clk;

    transducer_fire_sequencer #(
        .N_CH(N_CH), .PD_W(PD_W), .CT_W(CT_W), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk(clk), .rst(rst), .cfgWe(cfgWe), .cfgAddr(cfgAddr),
        .cfgPhaseDelay(cfgPhaseDelay), .cfgChargeTime(cfgChargeTime), .cfgMask(cfgMask),
        .trigger(trigger), .abort(abort), .faultClear(faultClear),
        .numFires(numFires), .interFireGap(interFireGap),
        .chPhaseDelay(chPhaseDelay), .chChargeTime(chChargeTime), .chMask(chMask),
        .onYourMark(onYourMark), .GOGOGO_EXCLAMATION(GOGOGO_EXCLAMATION), .chRst(chRst),
        .chFireComplete(chFireComplete), .chWarning(chWarning),
        .busy(busy), .done(done), .fault(fault), .faultChannels(faultChannels),
        .fireCount(fireCount)
    );

    // Reference model: current phase, cycles spent in it, and the train totals.
    int              mPhase, mAge, mShots, mTarget, mGap;
    bit              mAborted, mDone;
    logic [N_CH-1:0] mFaultCh;
    logic [PD_W-1:0] mPd [N_CH];
    logic [CT_W-1:0] mCt [N_CH];
    logic [N_CH-1:0] mMask;
    int              dly [N_CH];
    bit              noisy;
    int              nChecks, nFail, cyc;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic modelStep();
        int  nxt;
        int  oldPhase;
        bit  warn;
        bit  active;
        if (rst) begin
            mPhase = P_IDLE; mAge = 0; mShots = 0; mTarget = 0; mGap = 0;
            mAborted = 0; mDone = 0; mFaultCh = '0; mMask = '0;
            for (int i = 0; i < N_CH; i++) begin mPd[i] = '0; mCt[i] = '0; end
            return;
        end
        oldPhase = mPhase;
        warn     = (chWarning != '0);
        active   = (mPhase == P_ARM) || (mPhase == P_FIRE) || (mPhase == P_REL) || (mPhase == P_GAP);
        nxt      = mPhase;
        mDone    = 0;
        if (mPhase == P_IDLE && cfgWe) begin
            mPd[cfgAddr]   = cfgPhaseDelay;
            mCt[cfgAddr]   = cfgChargeTime;
            mMask[cfgAddr] = cfgMask;
        end
        if (active && warn) begin
            nxt      = P_FAULT;
            mFaultCh = chWarning;
        end else begin
            case (mPhase)
                P_IDLE: if (trigger && numFires != 0) begin
                    nxt = P_ARM; mTarget = numFires; mGap = interFireGap; mShots = 0;
                end
                P_ARM: if (abort) begin nxt = P_REL; mAborted = 1; end
                       else if (mAge == 1) nxt = P_FIRE;
                P_FIRE: if (abort) begin nxt = P_REL; mAborted = 1; end
                        else if (&chFireComplete) nxt = P_REL;
                        else if (mAge + 1 == FIRE_LIMIT) begin nxt = P_FAULT; mFaultCh = '0; end
                P_REL: if (mAborted) nxt = P_IDLE;
                       else begin
                           mShots++;
                           if (mShots == mTarget) begin nxt = P_IDLE; mDone = 1; end
                           else nxt = (mGap != 0) ? P_GAP : P_ARM;
                       end
                P_GAP: if (abort) begin nxt = P_REL; mAborted = 1; end
                       else if (mAge + 1 == mGap) nxt = P_ARM;
                P_FAULT: if (faultClear) begin nxt = P_CLR; mFaultCh = '0; end
                P_CLR: nxt = P_IDLE;
                default: nxt = P_IDLE;
            endcase
        end
        if (oldPhase == P_REL) mAborted = 0;
        mAge   = (nxt == mPhase) ? mAge + 1 : 0;
        mPhase = nxt;
    endtask

    task automatic compare();
        logic [N_CH*PD_W-1:0] ePd;
        logic [N_CH*CT_W-1:0] eCt;
        for (int i = 0; i < N_CH; i++) begin
            ePd[i*PD_W +: PD_W] = mPd[i];
            eCt[i*CT_W +: CT_W] = mCt[i];
        end
        chk("onYourMark", 256'(onYourMark), 256'(mPhase == P_ARM || mPhase == P_FIRE));
        chk("go", 256'(GOGOGO_EXCLAMATION), 256'(mPhase == P_FIRE));
        chk("chRst", 256'(chRst), 256'(mPhase == P_REL || mPhase == P_CLR || rst));
        chk("busy", 256'(busy), 256'(mPhase != P_IDLE));
        chk("done", 256'(done), 256'(mDone));
        chk("fault", 256'(fault), 256'(mPhase == P_FAULT));
        chk("faultChannels", 256'(faultChannels), 256'(mFaultCh));
        chk("fireCount", 256'(fireCount), 256'(16'(mShots)));
        chk("chPhaseDelay", 256'(chPhaseDelay), 256'(ePd));
        chk("chChargeTime", 256'(chChargeTime), 256'(eCt));
        chk("chMask", 256'(chMask), 256'(mMask));
    endtask

    // Channel array stand-in: channel i completes dly[i] cycles into FIRE.
    task automatic step();
        for (int i = 0; i < N_CH; i++)
            chFireComplete[i] = (mPhase == P_FIRE) ? (mAge >= dly[i]) :
                                (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
        modelStep();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic quiet();
        rst = 0; cfgWe = 0; trigger = 0; abort = 0; faultClear = 0; chWarning = '0;
    endtask

    task automatic setDly(input int d);
        for (int i = 0; i < N_CH; i++) dly[i] = d;
    endtask

    task automatic fire(input int nf, input int gap);
        trigger = 1; numFires = 16'(nf); interFireGap = 16'(gap);
        step();
        trigger = 0;
    endtask

    task automatic runToIdle(input string name);
        int k;
        k = 0;
        while (mPhase != P_IDLE && k < 200) begin step(); k++; end
        chk(name, 256'(k < 200), 256'(1));
    endtask

    initial begin
        int      k, relCyc, goCnt, doneCnt;
        int      spacing [$];
        logic    prevOym, prevRst;

        nChecks = 0; nFail = 0; cyc = 0; noisy = 0;
        quiet();
        cfgAddr = '0; cfgPhaseDelay = '0; cfgChargeTime = '0; cfgMask = 0;
        numFires = '0; interFireGap = '0; chFireComplete = '0;
        setDly(0);
        rst = 1;
        modelStep();
        @(negedge clk);
        step(); step();
        chk("rstChRst", 256'(chRst), 256'(1));
        chk("rstFireCount", 256'(fireCount), 256'(0));
        chk("rstTable", 256'(chPhaseDelay), 256'(0));
        rst = 0;
        step();

        // numFires = 0 is ignored
        fire(0, 0);
        chk("zeroShotsIgnored", 256'(busy), 256'(0));

        // Single shot, table all 4/10
        for (int i = 0; i < N_CH; i++) begin
            cfgWe = 1; cfgAddr = 3'(i); cfgPhaseDelay = 16'd4; cfgChargeTime = 9'd10; cfgMask = 0;
            step();
        end
        cfgWe = 0;
        setDly(2);
        fire(1, 0);
        chk("t1Arm1", 256'({onYourMark, GOGOGO_EXCLAMATION}), 256'(2'b10));
        step();
        chk("t1Arm2", 256'({onYourMark, GOGOGO_EXCLAMATION}), 256'(2'b10));
        step();
        chk("t1Go", 256'({onYourMark, GOGOGO_EXCLAMATION}), 256'(2'b11));
        chk("t1Pd", 256'(chPhaseDelay), {128'd0, {8{16'd4}}});
        chk("t1Ct", 256'(chChargeTime[8:0]), 256'(10));
        step(); step(); step();
        chk("t1Release", 256'({onYourMark, GOGOGO_EXCLAMATION, chRst}), 256'(3'b001));
        step();
        chk("t1Done", 256'({done, busy}), 256'(2'b10));
        chk("t1Count", 256'(fireCount), 256'(1));
        step();
        chk("t1DoneOnce", 256'(done), 256'(0));

        // Three shots, gap of 5
        setDly(1);
        fire(3, 5);
        spacing.delete(); doneCnt = 0; relCyc = -1; prevOym = 1; prevRst = 0; k = 0;
        do begin
            if (chRst && !prevRst) relCyc = cyc;
            if (onYourMark && !prevOym && relCyc >= 0) spacing.push_back(cyc - relCyc);
            prevOym = onYourMark; prevRst = chRst;
            step(); k++;
            doneCnt += int'(done);
        end while (mPhase != P_IDLE && k < 200);
        chk("t2Bound", 256'(k < 200), 256'(1));
        chk("t2Rearms", 256'(spacing.size()), 256'(2));
        if (spacing.size() == 2) begin
            chk("t2Spacing0", 256'(spacing[0]), 256'(6));
            chk("t2Spacing1", 256'(spacing[1]), 256'(6));
        end
        chk("t2Count", 256'(fireCount), 256'(3));
        chk("t2DoneCnt", 256'(doneCnt), 256'(1));

        // Channel 2 masked still completes
        cfgWe = 1; cfgAddr = 3'd2; cfgPhaseDelay = 16'd4; cfgChargeTime = 9'd10; cfgMask = 1;
        step();
        cfgWe = 0;
        setDly(3);
        fire(1, 0);
        doneCnt = 0; k = 0;
        while (mPhase != P_IDLE && k < 50) begin
            chk("t3Mask", 256'(chMask), 256'(8'h04));
            step(); k++;
            doneCnt += int'(done);
        end
        chk("t3Done", 256'(doneCnt), 256'(1));

        // Warning on channel 5 mid-FIRE
        setDly(8);
        fire(2, 0);
        repeat (5) step();
        chWarning = 8'h20;
        step();
        chWarning = '0;
        chk("t4Fault", 256'({fault, done}), 256'(2'b10));
        chk("t4Channels", 256'(faultChannels), 256'(8'h20));
        chk("t4Strobes", 256'({onYourMark, GOGOGO_EXCLAMATION, chRst}), 256'(3'b000));
        step(); step();
        chk("t4Held", 256'(fault), 256'(1));
        faultClear = 1;
        step();
        faultClear = 0;
        chk("t4Clear", 256'({chRst, fault, faultChannels}), 256'({1'b1, 1'b0, 8'h00}));
        step();
        chk("t4Idle", 256'({busy, done}), 256'(2'b00));

        // Watchdog: channel 0 never completes
        setDly(0); dly[0] = 1000;
        fire(1, 0);
        goCnt = 0; k = 0;
        while (k < 60) begin
            if (GOGOGO_EXCLAMATION) goCnt++;
            if (mPhase == P_FAULT) break;
            step(); k++;
        end
        chk("t5Bound", 256'(k < 60), 256'(1));
        chk("t5FireCycles", 256'(goCnt), 256'(15));
        chk("t5Fault", 256'({fault, faultChannels}), 256'({1'b1, 8'h00}));
        faultClear = 1; step(); faultClear = 0; step();

        // Config write during FIRE is ignored
        setDly(4);
        fire(1, 0);
        step(); step();
        cfgWe = 1; cfgAddr = 3'd0; cfgPhaseDelay = 16'hBEEF;
        step();
        cfgWe = 0;
        chk("t6Readback", 256'(chPhaseDelay[15:0]), 256'(16'd4));
        runToIdle("t6Bound");

        // Abort during GAP of a 4-shot train
        setDly(0);
        fire(4, 3);
        k = 0;
        while (mPhase != P_GAP && k < 30) begin step(); k++; end
        chk("t7Bound", 256'(k < 30), 256'(1));
        abort = 1;
        step();
        abort = 0;
        chk("t7Release", 256'({chRst, fireCount}), 256'({1'b1, 16'd1}));
        step();
        chk("t7Idle", 256'({busy, done, fireCount}), 256'({2'b00, 16'd1}));

        // Reset mid-FIRE
        setDly(5);
        fire(2, 0);
        step(); step();
        rst = 1;
        step();
        chk("t8Strobes", 256'({onYourMark, GOGOGO_EXCLAMATION, chRst, busy}), 256'(4'b0010));
        chk("t8Count", 256'(fireCount), 256'(0));
        chk("t8Table", 256'({chPhaseDelay, chMask}), 256'(0));
        rst = 0;
        step();

        // Random trains
        noisy = 1;
        for (int n = 0; n < 4000; n++) begin
            rst           = ($urandom_range(0, 999) == 0);
            cfgWe         = ($urandom_range(0, 5) == 0);
            cfgAddr       = 3'($urandom);
            cfgPhaseDelay = 16'($urandom);
            cfgChargeTime = 9'($urandom);
            cfgMask       = 1'($urandom);
            trigger       = (mPhase == P_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 20) == 0);
            numFires      = 16'($urandom_range(0, 4));
            interFireGap  = 16'($urandom_range(0, 4));
            abort         = ($urandom_range(0, 60) == 0);
            faultClear    = (mPhase == P_FAULT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 30) == 0);
            chWarning     = ($urandom_range(0, 150) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (mPhase == P_ARM)
                for (int i = 0; i < N_CH; i++)
                    dly[i] = ($urandom_range(0, 24) == 0) ? 40 : int'($urandom_range(0, 6));
            step();
        end
        quiet();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/transducer_fire_sequencer.md
# transducer_fire_sequencer

Central fire controller for an array of per-element transducer output channels. Holds a per-channel configuration table (phase delay, charge time, mask), broadcasts it to the channels, and runs the arm → fire → re-arm handshake for a programmed number of shots with an inter-shot gap. Aggregates channel completion and over-drive warnings and latches a fault that must be cleared explicitly. Sits between the host register interface and the channel array.

## Interface
- N_CH, 8: number of transducer channels
- PD_W, 16: phase-delay width per channel
- CT_W, 9: charge-time width per channel
- TIMEOUT_W, 20: watchdog width; fire phase faults after 2^TIMEOUT_W − 1 cycles
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfgWe  in  1  config table write strobe (accepted only in IDLE)
- cfgAddr  in  $clog2(N_CH)  channel index
- cfgPhaseDelay  in  PD_W  phase delay for cfgAddr
- cfgChargeTime  in  CT_W  charge time for cfgAddr
- cfgMask  in  1  1 = channel output suppressed
- trigger  in  1  start a shot train (IDLE only)
- abort  in  1  terminate train
- faultClear  in  1  leave FAULT
- numFires  in  16  shots per train, sampled on trigger
- interFireGap  in  16  idle cycles between shots, sampled on trigger
- chPhaseDelay  out  N_CH*PD_W  table broadcast, channel i at [i*PD_W +: PD_W]
- chChargeTime  out  N_CH*CT_W  table broadcast
- chMask  out  N_CH  table broadcast
- onYourMark  out  1  arm strobe to all channels
- GOGOGO_EXCLAMATION  out  1  fire strobe to all channels
- chRst  out  1  channel re-arm reset
- chFireComplete  in  N_CH  per-channel completion
- chWarning  in  N_CH  per-channel over-drive warning
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, train finished normally
- fault  out  1  state = FAULT
- faultChannels  out  N_CH  chWarning snapshot at fault entry (0 on timeout)
- fireCount  out  16  shots completed in current/last train

## Operation
- Table: registers, all zero after rst. cfgWe writes entry cfgAddr only in IDLE; ignored elsewhere; out-of-range address ignored. Outputs driven directly from table.
- States: IDLE, ARM, FIRE, RELEASE, GAP, FAULT.
- IDLE: trigger with numFires ≠ 0 → ARM; latch numFires/interFireGap, clear fireCount. trigger with numFires = 0 ignored.
- ARM: onYourMark=1, GO=0, exactly 2 cycles (channels latch config and drop completion), then FIRE.
- FIRE: onYourMark=1, GO=1; watchdog counts from 0. All chFireComplete bits high → RELEASE. Masked channels still complete normally.
- RELEASE: both strobes 0, chRst=1, one cycle; fireCount+1. If fireCount reaches numFires → IDLE with done; else GAP if interFireGap ≠ 0, else ARM.
- GAP: count interFireGap cycles, then ARM.
- Any non-zero chWarning in ARM/FIRE/RELEASE/GAP → FAULT (priority over all other transitions), snapshot faultChannels. Watchdog expiry in FIRE → FAULT, faultChannels=0.
- FAULT: strobes 0, chRst=0 (warnings stay visible). faultClear → one cycle chRst=1 → IDLE, fault and faultChannels clear; no done.
- abort in ARM/FIRE/GAP → RELEASE then IDLE, no done, fireCount not incremented. abort in FAULT/IDLE ignored.
- rst: IDLE, table zeroed, all outputs 0 except chRst=1 during rst; fireCount=0.

## Timing
- trigger sampled at cycle 0 → onYourMark=1 cycles 1–2, GO=1 from cycle 3.
- All completions sampled high at cycle k → RELEASE at k+1 (strobes low, chRst high) → next ARM/GAP/IDLE at k+2; done high at k+2 only.
- GAP of G cycles: next onYourMark rises G+1 cycles after RELEASE.
- Warning at cycle w → fault=1 at w+1, strobes low at w+1.
- Simultaneous trigger and cfgWe in IDLE: write applies; train uses new entry only from its first ARM (write lands same edge, visible cycle 1).
- Simultaneous abort and all-complete in FIRE: abort wins (no fireCount increment). Warning beats both.

## Test plan
- Single shot, chPhaseDelay all 4, chChargeTime all 10, numFires=1 → GO high from cycle 3, RELEASE one cycle after last completion, done pulse, fireCount=1.
- numFires=3, interFireGap=5 → three ARM/FIRE/RELEASE sequences, 6 cycles between RELEASE and next onYourMark, fireCount=3, one done.
- Channel 2 masked, others not → completion still reached, done asserted, chMask=0x04 stable throughout.
- chWarning[5]=1 mid-FIRE → fault=1 next cycle, faultChannels=0x20, strobes low, no done; faultClear → chRst pulse, IDLE.
- chFireComplete[0] held 0, TIMEOUT_W=4 → FAULT after 15 FIRE cycles, faultChannels=0.
- cfgWe during FIRE ignored (readback unchanged); abort during GAP of a 4-shot train → IDLE, fireCount unchanged, no done; rst mid-FIRE → all outputs 0, table zero.
